bus_uart_tx: RTL and testbench

BUS_UART_TX -- requirements
Module: bus_uart_tx

---
 rtl/bus_uart_pkg.sv | 46 ++++
 rtl/bus_uart_tx_fifo.sv | 68 ++++++
 rtl/bus_uart_tx.sv | 173 +++++++++++++++++
 tb/tb_bus_uart_tx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Holds register offsets, STATUS/CTRL bit positions, FSM state codes
// and a helper that packs the STATUS word.
package bus_uart_pkg;

    // Register byte offsets from BASE_ADDR
    localparam logic [31:0] OFF_TXDATA = 32'h0;
    localparam logic [31:0] OFF_STATUS = 32'h4;
    localparam logic [31:0] OFF_CTRL   = 32'h8;

    // STATUS bit positions; count occupies [ST_CNT_LSB +: 4]
    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    // CTRL bit positions
    localparam int CT_IEN     = 0;
    localparam int CT_FLUSH   = 1;
    localparam int CT_CLR_OVF = 2;

    // Transmit FSM encodings
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    function automatic logic [31:0] status_word(
        input logic [3:0] cnt,
        input logic       ovf,
        input logic       busy,
        input logic       empty,
        input logic       full
    );
        logic [31:0] w;
        w                   = '0;
        w[ST_CNT_LSB +: 4]  = cnt;
        w[ST_OVF]           = ovf;
        w[ST_BUSY]          = busy;
        w[ST_EMPTY]         = empty;
        w[ST_FULL]          = full;
        return w;
    endfunction

endpackage

// File: rtl/bus_uart_tx_fifo.sv
// uart_fifo: synchronous byte FIFO with show-ahead head output.
// Latency: a pushed entry is visible on head_o/empty_o the cycle after the push edge.
// Backpressure: push is ignored when full unless a pop happens at the same edge.
// Ports: clk, reset (sync, active-low), push_i/data_i, pop_i, flush_i,
//        head_o (current head), full_o, empty_o, count_o (occupancy 0..DEPTH).
module uart_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [W-1:0]             head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    // A full FIFO still accepts when the head leaves at the same edge.
    assign do_push = push_i & ~flush_i & (~full_o | do_pop);

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            // Drop everything queued; a same-edge pop has already taken the head.
            rd_ptr_q <= wr_ptr_q;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/bus_uart_tx.sv
// bus_uart_tx: CPU-bus mapped 8N1 UART transmitter with TX FIFO and drained irq.
// Latency: byte written at edge N starts its START bit at edge N+1; reads are combinational.
// Backpressure: none on the bus; writes to a full FIFO are dropped and flagged in STATUS.ovf.
// Ports: clk, reset (sync, active-low), MemBus_Address/Write_Data, MemRead, MemWrite,
//        Device_Read_Data (read data), uart_tx (serial out, idle high), irq (level).
module bus_uart_tx import bus_uart_pkg::*; #(
    parameter int          BAUD_DIV   = 868,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h4000_0010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] MemBus_Address,
    input  logic [31:0] MemBus_Write_Data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] Device_Read_Data,
    output logic        uart_tx,
    output logic        irq
);
    localparam int CW  = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

    logic sel_tx, sel_st, sel_ct, wr_tx, wr_ct;
    assign sel_tx = (MemBus_Address == BASE_ADDR + OFF_TXDATA);
    assign sel_st = (MemBus_Address == BASE_ADDR + OFF_STATUS);
    assign sel_ct = (MemBus_Address == BASE_ADDR + OFF_CTRL);
    assign wr_tx  = MemWrite & sel_tx;
    assign wr_ct  = MemWrite & sel_ct;

    logic           fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [7:0]     fifo_head;
    logic [FCW-1:0] fifo_count;

    assign fifo_push  = wr_tx & (~fifo_full | fifo_pop);
    assign fifo_flush = wr_ct & MemBus_Write_Data[CT_FLUSH];

    uart_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .data_i  (MemBus_Write_Data[7:0]),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          ovf_q, ien_q, irq_q;
    logic          bit_end, busy;

    assign bit_end = (baud_q == BAUD_LAST);
    assign busy    = (state_q != S_IDLE);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = S_START;
                    baud_d   = '0;
                    shift_d  = fifo_head;
                    tx_d     = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        // Shift register always holds the current bit in [0].
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        // Chain straight into the next START: no idle gap.
                        fifo_pop = 1'b1;
                        state_d  = S_START;
                        shift_d  = fifo_head;
                        tx_d     = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
            ien_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            if (wr_tx && fifo_full && !fifo_pop)
                ovf_q <= 1'b1;
            else if (wr_ct && MemBus_Write_Data[CT_CLR_OVF])
                ovf_q <= 1'b0;
            if (wr_ct) ien_q <= MemBus_Write_Data[CT_IEN];
            irq_q <= ien_q & fifo_empty & ~busy;
        end
    end

    assign uart_tx = tx_q;
    assign irq     = irq_q;

    // Read data reflects pre-edge register state, so a same-cycle write is not visible.
    always_comb begin
        Device_Read_Data = '0;
        if (MemRead) begin
            if (sel_st)
                Device_Read_Data = status_word(4'(fifo_count), ovf_q, busy,
                                               fifo_empty, fifo_full);
            else if (sel_ct)
                Device_Read_Data[CT_IEN] = ien_q;
        end
    end

    logic unused_wdata;
    assign unused_wdata = ^MemBus_Write_Data[31:8];

endmodule

// File: tb/tb_bus_uart_tx.sv
module tb_bus_uart_tx;
    localparam logic [31:0] BASE = 32'h4000_0010;
    localparam logic [31:0] A_TX = BASE;
    localparam logic [31:0] A_ST = BASE + 32'h4;
    localparam logic [31:0] A_CT = BASE + 32'h8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] MemBus_Address;
    logic [31:0] MemBus_Write_Data;
    logic        MemRead, MemWrite;
    logic [31:0] Device_Read_Data;
    logic        uart_tx, irq;

    int total = 0;
    int bad   = 0;

    logic [7:0] rx_q[$];
    logic [7:0] rx_b;
    int         rx_ferr = 0;

    always #5 clk = ~clk;

    bus_uart_tx #(.BAUD_DIV(4), .FIFO_DEPTH(8), .BASE_ADDR(BASE)) dut (
        .clk               (clk),
        .reset             (reset),
        .MemBus_Address    (MemBus_Address),
        .MemBus_Write_Data (MemBus_Write_Data),
        .MemRead           (MemRead),
        .MemWrite          (MemWrite),
        .Device_Read_Data  (Device_Read_Data),
        .uart_tx           (uart_tx),
        .irq               (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        MemBus_Address    = a;
        MemBus_Write_Data = d;
        MemWrite          = 1'b1;
        @(posedge clk); #1;
        MemWrite          = 1'b0;
    endtask

    task automatic rd_val(input logic [31:0] a, output logic [31:0] v);
        MemBus_Address = a;
        MemRead        = 1'b1;
        #1;
        v              = Device_Read_Data;
        MemRead        = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        rd_val(a, v);
        chk(tag, v, exp);
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return d[b-1];
    endfunction

    // Sample the line once per cycle, #1 after each edge; k=0 is the cycle after the pop edge.
    task automatic chk_frames(input logic [7:0] b0, input logic [7:0] b1,
                              input int nfr, input int k0);
        for (int k = k0; k < nfr * 40; k++) begin
            logic [7:0] d;
            @(posedge clk); #1;
            d = ((k / 40) == 0) ? b0 : b1;
            chk($sformatf("tx_k%0d", k), {31'b0, uart_tx}, {31'b0, exp_bit(d, (k % 40) / 4)});
        end
    endtask

    task automatic wait_idle(input int max_cyc);
        logic [31:0] v;
        int          n;
        n = 0;
        v = '0;
        while (n < max_cyc) begin
            @(posedge clk); #1;
            rd_val(A_ST, v);
            n++;
            if (!v[2] && v[1]) break;
        end
        chk("idle_timeout", {31'b0, (n >= max_cyc)}, 32'd0);
    endtask

    // Independent line receiver: mid-bit sampling at BAUD_DIV=4.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (reset === 1'b1 && uart_tx === 1'b0) begin
                repeat (6) @(posedge clk);
                #1 rx_b[0] = uart_tx;
                for (int i = 1; i < 8; i++) begin
                    repeat (4) @(posedge clk);
                    #1 rx_b[i] = uart_tx;
                end
                repeat (4) @(posedge clk);
                #1;
                if (uart_tx !== 1'b1) rx_ferr++;
                rx_q.push_back(rx_b);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        reset             = 1'b0;
        MemBus_Address    = '0;
        MemBus_Write_Data = '0;
        MemRead           = 1'b0;
        MemWrite          = 1'b0;

        // Reset state, read data tracking reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", {31'b0, uart_tx}, 32'd1);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        rd_chk("rst_status", A_ST, 32'h2);
        rd_chk("rst_ctrl", A_CT, 32'h0);
        rd_chk("rd_txdata", A_TX, 32'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        MemBus_Address = A_ST;
        MemRead        = 1'b0;
        #1 chk("no_memread", Device_Read_Data, 32'h0);
        rd_chk("unselected", BASE + 32'hC, 32'h0);

        // Single byte 0x55: pushed, not popped until the following edge
        bus_write(A_TX, 32'h55);
        rd_chk("single_status_q", A_ST, 32'h10);
        chk_frames(8'h55, 8'h00, 1, 0);
        @(posedge clk); #1;
        rd_chk("single_idle", A_ST, 32'h2);
        chk("single_tx_idle", {31'b0, uart_tx}, 32'd1);

        // Back-to-back 0x01, 0x80
        bus_write(A_TX, 32'h01);
        MemBus_Address    = A_TX;
        MemBus_Write_Data = 32'h80;
        MemWrite          = 1'b1;
        @(posedge clk); #1;
        MemWrite          = 1'b0;
        chk("b2b_tx_k0", {31'b0, uart_tx}, 32'd0);
        rd_chk("b2b_status", A_ST, 32'h14);
        chk_frames(8'h01, 8'h80, 2, 1);
        @(posedge clk); #1;
        rd_chk("b2b_idle", A_ST, 32'h2);

        // Overflow: 1 byte in flight, 9 more into a depth-8 FIFO
        rx_q.delete();
        bus_write(A_TX, 32'hA5);
        for (int i = 0; i < 9; i++) bus_write(A_TX, 32'h10 + i);
        rd_chk("ovf_status", A_ST, 32'h8D);
        bus_write(A_CT, 32'h4);
        rd_chk("ovf_cleared", A_ST, 32'h85);
        wait_idle(1000);
        chk("ovf_rx_count", rx_q.size(), 32'd9);
        for (int i = 0; i < 9; i++) begin
            logic [7:0] e;
            e = (i == 0) ? 8'hA5 : 8'(8'h10 + i - 1);
            chk($sformatf("ovf_rx%0d", i), (rx_q.size() > i) ? {24'b0, rx_q[i]} : 32'hx, {24'b0, e});
        end
        chk("ovf_ferr", rx_ferr, 32'd0);
        rd_chk("ovf_end_status", A_ST, 32'h2);

        // Flush mid-frame
        rx_q.delete();
        bus_write(A_TX, 32'h11);
        bus_write(A_TX, 32'h22);
        bus_write(A_TX, 32'h33);
        repeat (5) @(posedge clk);
        #1;
        rd_chk("flush_pre", A_ST, 32'h24);
        bus_write(A_CT, 32'h2);
        rd_chk("flush_post", A_ST, 32'h06);
        wait_idle(200);
        repeat (60) @(posedge clk);
        #1;
        chk("flush_rx_count", rx_q.size(), 32'd1);
        chk("flush_rx0", (rx_q.size() > 0) ? {24'b0, rx_q[0]} : 32'hx, 32'h11);
        rd_chk("flush_end_status", A_ST, 32'h2);

        // Interrupt, plus read+write in the same cycle
        MemBus_Address    = A_CT;
        MemBus_Write_Data = 32'h1;
        MemRead           = 1'b1;
        MemWrite          = 1'b1;
        #1 chk("rw_same_cycle", Device_Read_Data, 32'h0);
        @(posedge clk); #1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        rd_chk("ctrl_ien", A_CT, 32'h1);
        chk("irq_before_ien_seen", {31'b0, irq}, 32'd0);
        bus_write(A_TX, 32'h3C);
        chk("irq_idle_empty", {31'b0, irq}, 32'd1);
        @(posedge clk); #1;
        chk("irq_queued", {31'b0, irq}, 32'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("irq_busy", {31'b0, irq}, 32'd0);
        wait_idle(200);
        chk("irq_at_idle_edge", {31'b0, irq}, 32'd0);
        @(posedge clk); #1;
        chk("irq_drained", {31'b0, irq}, 32'd1);

        // Reset in the middle of DATA
        bus_write(A_TX, 32'hF0);
        repeat (9) @(posedge clk);
        #1;
        chk("tx_before_reset", {31'b0, uart_tx}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_mid_tx", {31'b0, uart_tx}, 32'd1);
        chk("rst_mid_irq", {31'b0, irq}, 32'd0);
        rd_chk("rst_mid_status", A_ST, 32'h2);
        rd_chk("rst_mid_ctrl", A_CT, 32'h0);
        reset = 1'b1;
        lows  = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (uart_tx !== 1'b1) lows++;
        end
        chk("no_resume", lows, 32'd0);
        rd_chk("post_rst_status", A_ST, 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
